demux2_reg: RTL
===============

# demux2_reg

Registered 1-to-2 stream demultiplexer: routes each beat of one valid/ready input stream to output 0 or 1 as selected by a per-beat select bit, through a one-entry holding register per output. It is the distribution end of the 2:1 selection path: a producer feeds it, and two independent consumers drain it with their own backpressure. Optional per-output beat counters support debug and bench checking.

## Interface
Parameters:
- DW, 8, data width
- CW, 16, beat-counter width (used only with DEMUX2_CNT_EN)

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid && o_ready
- i_sel  in  1  destination of current beat: 0 -> output 0, 1 -> output 1
- i_data  in  DW  input payload
- o_valid0  out  1  output 0 holds a beat
- i_ready0  in  1  consumer 0 ready
- o_data0  out  DW  output 0 payload
- o_valid1, i_ready1, o_data1: same as above, for output 1
- o_cnt0  out  CW  beats delivered on output 0 (DEMUX2_CNT_EN only)
- o_cnt1  out  CW  beats delivered on output 1 (DEMUX2_CNT_EN only)

## Operation
- Each output has a slot with a two-state FSM: EMPTY, FULL. o_validN = (state == FULL).
- Input handshake: acc = i_valid && o_ready. Output handshake: drN = o_validN && i_readyN.
- o_ready = i_sel ? (EMPTY1 || i_ready1) : (EMPTY0 || i_ready0). o_ready is combinational from i_sel and the selected side's state and ready. The other side is ignored.
- Slot N transitions:
  - EMPTY -> FULL on acc with i_sel == N; o_dataN is loaded with i_data.
  - FULL -> EMPTY on drN without a fill.
  - FULL -> FULL on drN and a simultaneous fill. The new data replaces the old data, and no bubble is inserted.
  - FULL with no drN holds o_dataN stable, and o_validN stays high.
- Head-of-line blocking is required: a beat targeting a FULL, non-draining slot stalls the input even if the other slot is EMPTY. No reordering; beats to the same output leave in arrival order.
- The two outputs drain independently. Both can fire in the same cycle.
- o_dataN is don't-care while o_validN = 0. Data is not cleared on drain.
- Reset (asynchronous, any time including mid-transfer): both slots go to EMPTY, held beats are discarded, o_valid0/1 = 0, o_data0/1 = 0, and counters = 0. o_ready follows its equation, which gives 1 after reset.

## Timing
- Latency: a beat accepted at edge k is visible on o_validN/o_dataN after edge k; the earliest drain is at edge k+1.
- Throughput: 1 beat/cycle per output when the consumer holds readyN high. Any alternating i_sel pattern also sustains 1 beat/cycle.
- Outputs o_valid*, o_data*, and o_cnt* are registered. o_ready is the only combinational output.
- The producer must hold i_valid, i_sel, and i_data stable until acc. The block does not check this.

## Configuration
- DEMUX2_CNT_EN defined:
  - o_cnt0/o_cnt1 exist.
  - Each is a CW-bit counter incremented on drN.
  - Each wraps from 2^CW-1 to 0 without saturation.
  - Each resets to 0.
- DEMUX2_CNT_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Package demux2_pkg:
  - slot state typedef: enum {EMPTY, FULL}
  - default DW/CW constants
- Sub-module demux2_slot:
  - one-entry register slot with load/drain, its FSM, and the optional counter
  - instantiated twice (N = 0, 1)
  - top-level logic is limited to the o_ready mux and fill routing

## Test plan
- Reset asserted mid-transfer with both slots FULL -> o_valid0/1 = 0, o_data0/1 = 0, o_ready = 1, and o_cnt0/1 = 0 immediately, without waiting for a clock edge.
- Stream 0x11, 0x22, 0x33 with i_sel = 0, 1, 0 and both readies high -> o_data0 delivers 0x11 then 0x33, o_data1 delivers 0x22, 1 beat/cycle, no bubbles.
- i_ready0 = 0 and slot 0 FULL with 0xA5; present i_sel = 0, i_data = 0x5A -> o_ready = 0, and 0xA5 stays stable. Raise i_ready0 -> 0xA5 drains and 0x5A loads in the same cycle.
- Head-of-line case: slot 0 FULL and stalled, slot 1 EMPTY, beat with i_sel = 0 -> o_ready = 0, and o_valid1 stays 0.
- Random i_valid/i_sel/i_ready0/i_ready1 for 10k cycles -> per-output scoreboard matches in order; no loss or duplication.
- With DEMUX2_CNT_EN and CW = 4: 17 drains on output 1 -> o_cnt1 = 1 (wrapped), o_cnt0 = 0.

Source files
------------

// File: rtl/demux2_pkg.sv
// demux2_pkg: shared types and default sizes for the demux2_reg slice.
//   slot_state_e : one-entry slot occupancy (EMPTY / FULL)
//   DW_DEF       : default payload width
//   CW_DEF       : default beat-counter width (counters exist only with DEMUX2_CNT_EN)
package demux2_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CW_DEF = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage : demux2_pkg

// File: rtl/demux2_slot.sv
// demux2_slot: one-entry output holding register with valid/ready drain side.
// Optional macro DEMUX2_CNT_EN adds a wrapping count of drained beats.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_fill        : load i_data this cycle (caller guarantees slot is empty or draining)
//   i_data        : payload to load
//   i_ready       : downstream consumer ready
//   o_valid       : slot holds a beat
//   o_data        : held payload (don't-care while o_valid = 0)
//   o_cnt         : beats drained so far (DEMUX2_CNT_EN only)
module demux2_slot
  import demux2_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
`ifdef DEMUX2_CNT_EN
  , parameter int unsigned CW = CW_DEF
`endif
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_fill,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data
`ifdef DEMUX2_CNT_EN
  , output logic [CW-1:0] o_cnt
`endif
);

  slot_state_e   state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          drain;

  // Consumer takes the held beat this cycle.
  assign drain = (state_q == FULL) && i_ready;

  // Next state and payload; a fill while draining keeps the slot FULL with no bubble.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: if (i_fill) state_d = FULL;
      FULL:  if (drain && !i_fill) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (i_fill) data_d = i_data;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = (state_q == FULL);
  assign o_data  = data_q;

`ifdef DEMUX2_CNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  // Free-running drained-beat count, wraps without saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (drain) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;
`endif

endmodule : demux2_slot

// File: rtl/demux2_reg.sv
// demux2_reg: registered 1-to-2 valid/ready stream demultiplexer.
// Each input beat is routed by i_sel into a one-entry slot per output.
// Optional macro DEMUX2_CNT_EN adds per-output drained-beat counters.
// Ports:
//   i_clk, i_rstn               : clock, asynchronous active-low reset
//   i_valid, o_ready            : input handshake (o_ready is combinational)
//   i_sel, i_data               : destination select and payload of current beat
//   o_valid0, i_ready0, o_data0 : output 0 stream
//   o_valid1, i_ready1, o_data1 : output 1 stream
//   o_cnt0, o_cnt1              : drained beat counts (DEMUX2_CNT_EN only)
module demux2_reg
  import demux2_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
`ifdef DEMUX2_CNT_EN
  , parameter int unsigned CW = CW_DEF
`endif
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_sel,
  input  logic [DW-1:0] i_data,
  output logic          o_valid0,
  input  logic          i_ready0,
  output logic [DW-1:0] o_data0,
  output logic          o_valid1,
  input  logic          i_ready1,
  output logic [DW-1:0] o_data1
`ifdef DEMUX2_CNT_EN
  , output logic [CW-1:0] o_cnt0
  , output logic [CW-1:0] o_cnt1
`endif
);

  logic acc;
  logic fill0;
  logic fill1;

  // Only the selected side gates the input: a stalled target blocks the
  // stream even if the other slot is empty (in-order, head-of-line blocking).
  assign o_ready = i_sel ? (!o_valid1 || i_ready1) : (!o_valid0 || i_ready0);
  assign acc     = i_valid && o_ready;
  assign fill0   = acc && !i_sel;
  assign fill1   = acc &&  i_sel;

  demux2_slot #(
    .DW (DW)
`ifdef DEMUX2_CNT_EN
    , .CW (CW)
`endif
  ) u_slot0 (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_fill  (fill0),
    .i_data  (i_data),
    .i_ready (i_ready0),
    .o_valid (o_valid0),
    .o_data  (o_data0)
`ifdef DEMUX2_CNT_EN
    , .o_cnt (o_cnt0)
`endif
  );

  demux2_slot #(
    .DW (DW)
`ifdef DEMUX2_CNT_EN
    , .CW (CW)
`endif
  ) u_slot1 (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_fill  (fill1),
    .i_data  (i_data),
    .i_ready (i_ready1),
    .o_valid (o_valid1),
    .o_data  (o_data1)
`ifdef DEMUX2_CNT_EN
    , .o_cnt (o_cnt1)
`endif
  );

endmodule : demux2_reg
